// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous SRAM between instruction fetch (IF)
//   and the execute-stage load/store port (EX). One requester is granted
//   per cycle. The grant is combinational in the request cycle. Read data
//   comes back one cycle later and is routed by a registered owner tag.
//
//   Build option: define VENUS_ARB_RR_EN to arbitrate contention with a
//   1-bit round-robin pointer. Without it, EX has fixed priority and IF is
//   protected from starvation by a saturating wait counter. After MAX_WAIT
//   consecutive denied cycles, IF wins the next contended cycle.

module mem_port_arbiter #(
  parameter int ADDR     = 16,
  parameter int W_DATA   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // fetch port
  input  logic              if_req_i,
  input  logic [ADDR-1:0]   if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [W_DATA-1:0] if_rdata_o,
  // execute load/store port
  input  logic              ex_req_i,
  input  logic              ex_we_i,
  input  logic [ADDR-1:0]   ex_addr_i,
  input  logic [W_DATA-1:0] ex_wdata_i,
  output logic              ex_gnt_o,
  output logic              ex_rvalid_o,
  output logic [W_DATA-1:0] ex_rdata_o,
  output logic              ex_stall_o,
  // memory macro
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR-1:0]   mem_addr_o,
  output logic [W_DATA-1:0] mem_wdata_o,
  input  logic [W_DATA-1:0] mem_rdata_i
);

  // Owner tag encoding for the read return path
  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_EX = 1'b1;

  logic w_if_gnt;
  logic w_ex_gnt;
  logic w_contended;

  // A read is outstanding and returns this cycle to r_owner
  logic r_rvalid;
  logic r_owner;

`ifdef VENUS_ARB_RR_EN
  // 1 = IF preferred on the next contended cycle, 0 = EX preferred
  logic r_rr_ptr;
  logic w_rr_ptr_nxt;
`else
  localparam int          W_CNT   = 4;
  localparam logic [W_CNT-1:0] LP_MAX = W_CNT'(MAX_WAIT);

  logic [W_CNT-1:0] r_wait_cnt;
  logic [W_CNT-1:0] w_wait_cnt_nxt;
  logic             w_if_starved;
`endif

  assign w_contended = if_req_i & ex_req_i;

`ifdef VENUS_ARB_RR_EN
  // Round-robin pointer: after a contended grant it points at the loser
  always_comb begin
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_contended && reset) begin
      w_rr_ptr_nxt = w_ex_gnt;
    end else begin
      w_rr_ptr_nxt = r_rr_ptr;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= 1'b0;
    end else begin
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end
`else
  assign w_if_starved = (r_wait_cnt == LP_MAX);

  // Wait counter: count denied IF cycles, saturate, clear when IF is served or idle
  always_comb begin
    w_wait_cnt_nxt = '0;
    if (if_req_i && !w_if_gnt) begin
      if (w_if_starved) begin
        w_wait_cnt_nxt = r_wait_cnt;
      end else begin
        w_wait_cnt_nxt = r_wait_cnt + W_CNT'(1);
      end
    end else begin
      w_wait_cnt_nxt = '0;
    end
  end

  // Wait counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end
`endif

  // Grant selection: at most one grant, none while reset is held
  always_comb begin
    w_if_gnt = 1'b0;
    w_ex_gnt = 1'b0;
    if (!reset) begin
      w_if_gnt = 1'b0;
      w_ex_gnt = 1'b0;
    end else if (w_contended) begin
`ifdef VENUS_ARB_RR_EN
      if (r_rr_ptr) begin
        w_if_gnt = 1'b1;
      end else begin
        w_ex_gnt = 1'b1;
      end
`else
      if (w_if_starved) begin
        w_if_gnt = 1'b1;
      end else begin
        w_ex_gnt = 1'b1;
      end
`endif
    end else if (if_req_i) begin
      w_if_gnt = 1'b1;
    end else if (ex_req_i) begin
      w_ex_gnt = 1'b1;
    end else begin
      w_if_gnt = 1'b0;
      w_ex_gnt = 1'b0;
    end
  end

  // Memory command mux: the granted requester drives the macro, idle is all zero
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_ex_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = ex_we_i;
      mem_addr_o  = ex_addr_i;
      mem_wdata_o = ex_wdata_i;
    end else if (w_if_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b0;
      mem_addr_o  = if_addr_i;
      mem_wdata_o = '0;
    end else begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
    end
  end

  // Read return tag: remember who issued a read; stores and idle cycles clear it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rvalid <= 1'b0;
      r_owner  <= OWNER_IF;
    end else if (w_ex_gnt) begin
      r_rvalid <= ~ex_we_i;
      r_owner  <= OWNER_EX;
    end else if (w_if_gnt) begin
      r_rvalid <= 1'b1;
      r_owner  <= OWNER_IF;
    end else begin
      r_rvalid <= 1'b0;
      r_owner  <= r_owner;
    end
  end

  // Read data routing: only the tagged owner sees data, the other side reads zero
  always_comb begin
    if_rvalid_o = 1'b0;
    ex_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    ex_rdata_o  = '0;
    if (reset && r_rvalid) begin
      case (r_owner)
        OWNER_IF: begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = mem_rdata_i;
        end
        OWNER_EX: begin
          ex_rvalid_o = 1'b1;
          ex_rdata_o  = mem_rdata_i;
        end
        default: begin
          if_rvalid_o = 1'b0;
          ex_rvalid_o = 1'b0;
        end
      endcase
    end else begin
      if_rvalid_o = 1'b0;
      ex_rvalid_o = 1'b0;
    end
  end

  assign if_gnt_o   = w_if_gnt;
  assign ex_gnt_o   = w_ex_gnt;
  assign ex_stall_o = reset & ex_req_i & ~w_ex_gnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small SRAM model.
// Expected grant patterns depend on VENUS_ARB_RR_EN.

module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ex_req;
  logic        ex_we;
  logic [15:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        ex_gnt;
  logic        ex_rvalid;
  logic [31:0] ex_rdata;
  logic        ex_stall;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.ADDR(16), .W_DATA(32), .MAX_WAIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_gnt_o    (if_gnt),
    .if_rvalid_o (if_rvalid),
    .if_rdata_o  (if_rdata),
    .ex_req_i    (ex_req),
    .ex_we_i     (ex_we),
    .ex_addr_i   (ex_addr),
    .ex_wdata_i  (ex_wdata),
    .ex_gnt_o    (ex_gnt),
    .ex_rvalid_o (ex_rvalid),
    .ex_rdata_o  (ex_rdata),
    .ex_stall_o  (ex_stall),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port SRAM model; preloads 0x0010 while reset is low
  always @(posedge clk) begin
    if (!reset) begin
      mem[8'h10] <= 32'hDEADBEEF;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic prev_if;
    logic prev_ex;
    logic exp_if;

    reset    = 1'b0;
    if_req   = 1'b1;
    ex_req   = 1'b1;
    if_addr  = 16'h0010;
    ex_addr  = 16'h0020;
    ex_we    = 1'b0;
    ex_wdata = 32'h0;
    tick();
    tick();

    // 1: reset held with both requesting
    chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("rst_ex_gnt", {31'd0, ex_gnt}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_stall", {31'd0, ex_stall}, 32'd0);
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_ex_rdata", ex_rdata, 32'd0);

    reset = 1'b1;
    #1;
    chk("rel_ex_gnt", {31'd0, ex_gnt}, 32'd1);
    chk("rel_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("rel_mem_addr", {16'd0, mem_addr}, 32'h0020);
    tick();
    if_req = 1'b0;
    ex_req = 1'b0;
    #1;
    chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
    chk("idle_mem_addr", {16'd0, mem_addr}, 32'd0);
    tick();

    // 2: lone IF read of 0x0010
    if_req  = 1'b1;
    if_addr = 16'h0010;
    #1;
    chk("if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("if_ex_gnt", {31'd0, ex_gnt}, 32'd0);
    chk("if_mem_en", {31'd0, mem_en}, 32'd1);
    chk("if_mem_we", {31'd0, mem_we}, 32'd0);
    chk("if_mem_addr", {16'd0, mem_addr}, 32'h0010);
    tick();
    if_req = 1'b0;
    #1;
    chk("if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("if_rdata", if_rdata, 32'hDEADBEEF);
    chk("if_ex_rvalid", {31'd0, ex_rvalid}, 32'd0);
    chk("if_ex_rdata", ex_rdata, 32'd0);
    tick();
    chk("if_rvalid_clr", {31'd0, if_rvalid}, 32'd0);

    // 3: EX store then load of 0x0020
    ex_req   = 1'b1;
    ex_we    = 1'b1;
    ex_addr  = 16'h0020;
    ex_wdata = 32'h12345678;
    #1;
    chk("st_gnt", {31'd0, ex_gnt}, 32'd1);
    chk("st_stall", {31'd0, ex_stall}, 32'd0);
    chk("st_mem_we", {31'd0, mem_we}, 32'd1);
    chk("st_mem_wdata", mem_wdata, 32'h12345678);
    tick();
    ex_we = 1'b0;
    #1;
    chk("st_no_rvalid", {31'd0, ex_rvalid}, 32'd0);
    chk("ld_gnt", {31'd0, ex_gnt}, 32'd1);
    chk("ld_stall", {31'd0, ex_stall}, 32'd0);
    chk("ld_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    ex_req = 1'b0;
    #1;
    chk("ld_rvalid", {31'd0, ex_rvalid}, 32'd1);
    chk("ld_rdata", ex_rdata, 32'h12345678);
    chk("ld_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    tick();

    // 4/5: continuous contention; rvalid follows the previous cycle's owner
    prev_if = 1'b0;
    prev_ex = 1'b0;
    if_req  = 1'b1;
    ex_req  = 1'b1;
    ex_we   = 1'b0;
    if_addr = 16'h0010;
    ex_addr = 16'h0020;
    for (int k = 0; k < 10; k++) begin
      #1;
`ifdef VENUS_ARB_RR_EN
      // pointer was left on IF by the contended grant at reset release
      exp_if = ((k % 2) == 0);
`else
      exp_if = ((k % 5) == 4);
`endif
      chk($sformatf("ct_if_gnt_%0d", k), {31'd0, if_gnt}, {31'd0, exp_if});
      chk($sformatf("ct_ex_gnt_%0d", k), {31'd0, ex_gnt}, {31'd0, ~exp_if});
      chk($sformatf("ct_stall_%0d", k), {31'd0, ex_stall}, {31'd0, exp_if});
      chk($sformatf("ct_if_rv_%0d", k), {31'd0, if_rvalid}, {31'd0, prev_if});
      chk($sformatf("ct_ex_rv_%0d", k), {31'd0, ex_rvalid}, {31'd0, prev_ex});
      chk($sformatf("ct_if_rd_%0d", k), if_rdata, prev_if ? 32'hDEADBEEF : 32'd0);
      chk($sformatf("ct_ex_rd_%0d", k), ex_rdata, prev_ex ? 32'h12345678 : 32'd0);
      prev_if = exp_if;
      prev_ex = ~exp_if;
      tick();
    end
    if_req = 1'b0;
    ex_req = 1'b0;
    #1;
    chk("ct_tail_if_rv", {31'd0, if_rvalid}, {31'd0, prev_if});
    chk("ct_tail_ex_rv", {31'd0, ex_rvalid}, {31'd0, prev_ex});
    tick();

    // 6: reset pulse right after an IF read grant discards the return
    if_req = 1'b1;
    #1;
    chk("rp_if_gnt", {31'd0, if_gnt}, 32'd1);
    tick();
    reset  = 1'b0;
    if_req = 1'b0;
    #1;
    chk("rp_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rp_if_rdata", if_rdata, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("rp_if_rvalid_rel", {31'd0, if_rvalid}, 32'd0);
    tick();
    chk("rp_if_rvalid_after", {31'd0, if_rvalid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
